// File: rtl/ysyx_22040895_mdu.sv
// ysyx_22040895_mdu -- iterative radix-2 multiply/divide unit for the RV64 EXU.
// Each BUSY cycle performs one shift-add (multiply) or one restoring step (divide).
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   valid_i_mdu        start request, taken only while ready_o_mdu is high
//   mduop_i_mdu        operation code (mul/mulw/div/divw/rem/remw)
//   src1_i_mdu/src2    rs1 / rs2 operand values
//   flush_i_mdu        abort the current operation; blocks an accept in IDLE
//   ready_o_mdu        high in IDLE only
//   done_o_mdu         one-cycle pulse, result_o_mdu valid in this cycle
//   result_o_mdu       result, held until the next completed operation
//   busy_o_mdu         high in BUSY or DONE (stall request)
module ysyx_22040895_mdu #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            valid_i_mdu,
  input  logic [3:0]      mduop_i_mdu,
  input  logic [XLEN-1:0] src1_i_mdu,
  input  logic [XLEN-1:0] src2_i_mdu,
  input  logic            flush_i_mdu,
  output logic            ready_o_mdu,
  output logic            done_o_mdu,
  output logic [XLEN-1:0] result_o_mdu,
  output logic            busy_o_mdu
);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t          r_state, w_next;
  logic [6:0]      r_cnt;
  logic [XLEN-1:0] r_a;      // multiplicand / divisor magnitude
  logic [XLEN-1:0] r_b;      // multiplier / {dividend, quotient} shift register
  logic [XLEN-1:0] r_acc;    // product accumulator / partial remainder
  logic [XLEN-1:0] r_result;
  logic            r_w, r_div, r_rem, r_sq, r_sr;

  // ---- decode of the incoming request ----
  logic            w_legal, w_is_w, w_is_div, w_is_rem, w_dz, w_accept;
  logic            w_s1, w_s2;
  logic [XLEN-1:0] w_op1, w_op2, w_mag1, w_mag2;

  always_comb begin
    w_legal  = mduop_i_mdu inside {4'b0001, 4'b0101, 4'b1001, 4'b1101, 4'b0011, 4'b0111};
    w_is_w   = ~mduop_i_mdu[1] & (mduop_i_mdu[2] | mduop_i_mdu[3]);
    w_is_div = mduop_i_mdu[1] | mduop_i_mdu[3];
    w_is_rem = mduop_i_mdu[2] & (mduop_i_mdu[1] | mduop_i_mdu[3]);
    w_op1    = w_is_w ? {{32{src1_i_mdu[31]}}, src1_i_mdu[31:0]} : src1_i_mdu;
    w_op2    = w_is_w ? {{32{src2_i_mdu[31]}}, src2_i_mdu[31:0]} : src2_i_mdu;
    w_s1     = w_op1[XLEN-1];
    w_s2     = w_op2[XLEN-1];
    w_mag1   = w_s1 ? -w_op1 : w_op1;
    w_mag2   = w_s2 ? -w_op2 : w_op2;
    w_dz     = w_is_div & (w_op2 == '0);
    w_accept = valid_i_mdu & (r_state == S_IDLE) & w_legal & ~flush_i_mdu;
  end

  // ---- one iteration of each algorithm ----
  logic [XLEN:0]   w_rem_sh;
  logic            w_ge;
  logic [XLEN-1:0] w_sub;

  always_comb begin
    // Next dividend bit always leaves from the MSB of r_b; W divides are
    // preloaded into the upper half so 32 steps consume exactly their bits.
    w_rem_sh = {r_acc, r_b[XLEN-1]};
    w_ge     = w_rem_sh >= {1'b0, r_a};
    // Partial remainder stays below 2*divisor, so the difference fits XLEN bits.
    w_sub    = w_rem_sh[XLEN-1:0] - r_a;
  end

  // ---- sign correction and W extension of the finished result ----
  logic [XLEN-1:0] w_q, w_r, w_raw, w_final;

  always_comb begin
    w_q     = r_sq ? -r_b : r_b;
    w_r     = r_sr ? -r_acc : r_acc;
    w_raw   = r_div ? (r_rem ? w_r : w_q) : r_acc;
    w_final = r_w ? {{32{w_raw[31]}}, w_raw[31:0]} : w_raw;
  end

  // ---- FSM: state register ----
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // ---- FSM: next state ----
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (w_accept) w_next = w_dz ? S_DONE : S_BUSY;
      S_BUSY: if (flush_i_mdu) w_next = S_IDLE;
              else if (r_cnt == 7'd1) w_next = S_DONE;
      S_DONE: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // ---- FSM: outputs ----
  always_comb begin
    ready_o_mdu  = (r_state == S_IDLE);
    busy_o_mdu   = (r_state != S_IDLE);
    done_o_mdu   = (r_state == S_DONE) & ~flush_i_mdu;
    result_o_mdu = done_o_mdu ? w_final : r_result;
  end

  // ---- datapath ----
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt    <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_acc    <= '0;
      r_result <= '0;
      r_w      <= 1'b0;
      r_div    <= 1'b0;
      r_rem    <= 1'b0;
      r_sq     <= 1'b0;
      r_sr     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (w_accept) begin
          r_w   <= w_is_w;
          r_div <= w_is_div;
          r_rem <= w_is_rem;
          r_cnt <= w_is_w ? 7'd32 : 7'd64;
          r_acc <= '0;
          if (w_dz) begin
            // Divide by zero: all-ones quotient, remainder is the dividend.
            r_b  <= '1;
            r_acc <= w_op1;
            r_sq <= 1'b0;
            r_sr <= 1'b0;
          end else if (w_is_div) begin
            r_a  <= w_mag2;
            r_b  <= w_is_w ? {w_mag1[31:0], 32'b0} : w_mag1;
            r_sq <= w_s1 ^ w_s2;
            r_sr <= w_s1;
          end else begin
            r_a  <= w_op1;
            r_b  <= w_op2;
            r_sq <= 1'b0;
            r_sr <= 1'b0;
          end
        end
        S_BUSY: if (!flush_i_mdu) begin
          r_cnt <= r_cnt - 7'd1;
          if (r_div) begin
            r_acc <= w_ge ? w_sub : w_rem_sh[XLEN-1:0];
            r_b   <= {r_b[XLEN-2:0], w_ge};
          end else begin
            if (r_b[0]) r_acc <= r_acc + r_a;
            r_a <= r_a << 1;
            r_b <= r_b >> 1;
          end
        end
        S_DONE: begin
          r_cnt <= '0;
          if (!flush_i_mdu) r_result <= w_final;
        end
        default: ;
      endcase
    end
  end

endmodule
